// File: rtl/alu_pkg.sv
// Shared encodings for the sequential N-bit ALU: opcode values and controller states.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic isAddSub(input logic [2:0] opCode);
    return (opCode == OP_ADD) || (opCode == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_adder_n.sv
// WIDTH-bit ripple-carry adder shared by ADD, SUB and the multiply partial sums.
module alu_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carryChain;

  assign carryChain[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]          = x[i] ^ y[i] ^ carryChain[i];
    assign carryChain[i+1] = (x[i] & y[i]) | (carryChain[i] & (x[i] ^ y[i]));
  end

  assign cout = carryChain[WIDTH];

endmodule

// File: rtl/alu_nbit_seq.sv
// Handshaked N-bit ALU: single-cycle logic/arith ops, iterative shift-add multiply,
// result and flags held in DONE until the consumer takes them.
module alu_nbit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   addX, addY, addSum;
  logic               addCin, addCout;
  logic [2*WIDTH-1:0] mulStep;
  logic               lastBit;
  logic [WIDTH-1:0]   opResult;
  logic               opCarry, opOvf, sltBit;

  // In MUL the adder accumulates the multiplicand into the high half; otherwise it serves ADD/SUB.
  always_comb begin
    addX   = a;
    addY   = b;
    addCin = 1'b0;
    if (state_q == S_MUL) begin
      addX = acc_q[2*WIDTH-1:WIDTH];
      addY = acc_q[0] ? mcand_q : '0;
    end else if (op == OP_SUB) begin
      addY   = ~b;
      addCin = 1'b1;
    end
  end

  alu_adder_n #(.WIDTH(WIDTH)) u_adder (
    .x    (addX),
    .y    (addY),
    .cin  (addCin),
    .sum  (addSum),
    .cout (addCout)
  );

  assign mulStep = {addCout, addSum, acc_q[WIDTH-1:1]};
  assign lastBit = (count_q == CW'(WIDTH - 1));
  assign sltBit  = $signed(a) < $signed(b);

  always_comb begin
    opResult = '0;
    opCarry  = 1'b0;
    opOvf    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        opResult = addSum;
        opCarry  = addCout;
        opOvf    = (a[WIDTH-1] == addY[WIDTH-1]) && (addSum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  opResult = a & b;
      OP_OR:   opResult = a | b;
      OP_XOR:  opResult = a ^ b;
      OP_SLT:  opResult = {{(WIDTH-1){1'b0}}, sltBit};
      default: opResult = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = (op == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (lastBit) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Non-MUL results are registered on the accepting edge; MUL results on its final iteration.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          count_d = '0;
          if (op == OP_MUL) begin
            acc_d = {{WIDTH{1'b0}}, b};
          end else begin
            result_d = opResult;
            carry_d  = opCarry;
            zero_d   = (opResult == '0);
            ovf_d    = opOvf;
          end
        end
      end
      S_MUL: begin
        acc_d   = mulStep;
        count_d = count_q + CW'(1);
        if (lastBit) begin
          result_d = mulStep[WIDTH-1:0];
          carry_d  = |mulStep[2*WIDTH-1:WIDTH];
          zero_d   = (mulStep[WIDTH-1:0] == '0);
          ovf_d    = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Self-checking bench for alu_nbit_seq at WIDTH=8: vector table, random ops against a
// reference model, backpressure and reset-during-multiply sequences.
module tb_alu_nbit_seq;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry, zero, overflow;

  int   errors = 0;
  int   checks = 0;
  exp_t sbQ[$];
  vec_t vecs[15];

  always #5 clk = ~clk;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t refModel(input logic [2:0] fop, input logic [W-1:0] fa, input logic [W-1:0] fb);
    exp_t           e;
    int             sa, sb, s;
    logic [W:0]     full;
    logic [2*W-1:0] p;
    sa = int'($signed(fa));
    sb = int'($signed(fb));
    s  = 0;
    e.res = '0;
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.lat = 0;
    case (fop)
      OP_ADD: begin
        full  = {1'b0, fa} + {1'b0, fb};
        e.res = full[W-1:0];
        e.c   = full[W];
        s     = sa + sb;
        e.v   = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
      end
      OP_SUB: begin
        e.res = fa - fb;
        e.c   = (fa >= fb);
        s     = sa - sb;
        e.v   = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
      end
      OP_AND: e.res = fa & fb;
      OP_OR:  e.res = fa | fb;
      OP_XOR: e.res = fa ^ fb;
      OP_SLT: e.res = (sa < sb) ? W'(1) : W'(0);
      OP_MUL: begin
        p     = {{W{1'b0}}, fa} * {{W{1'b0}}, fb};
        e.res = p[W-1:0];
        e.c   = |p[2*W-1:W];
        e.lat = W;
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic applyStimulus(input logic [2:0] sOp, input logic [W-1:0] sA, input logic [W-1:0] sB, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_timeout: got in_ready=0, required 1 within 50 cycles");
    end
    in_valid = 1'b1;
    op = sOp;
    a  = sA;
    b  = sB;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    op = 3'($urandom_range(0, 7));
  endtask

  task automatic checkOutput(input string name);
    int   cycles;
    exp_t e;
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_scoreboard: got empty queue, required a pending expectation", name);
      return;
    end
    e = sbQ.pop_front();
    if (!out_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got out_valid=0, required 1 within 100 cycles", name);
      return;
    end
    check({name, "_latency"}, 64'(cycles), 64'(e.lat));
    check({name, "_result"}, 64'({result, carry, zero, overflow}), 64'({e.res, e.c, e.z, e.v}));
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({name, "_drop"}, 64'(out_valid), 64'(0));
    end
  endtask

  initial begin
    int   stray;
    exp_t e;

    vecs[0]  = '{OP_ADD,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{OP_SUB,  8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{OP_MUL,  8'h10, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{OP_MUL,  8'h07, 8'h06, 8'h2A, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_SLT,  8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_XOR,  8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_RSVD, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{OP_OR,   8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{OP_SLT,  8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{OP_SUB,  8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{OP_MUL,  8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_outputs", 64'({result, carry, zero, overflow}), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      e.res = vecs[i].res;
      e.c   = vecs[i].c;
      e.z   = vecs[i].z;
      e.v   = vecs[i].v;
      e.lat = (vecs[i].op == OP_MUL) ? W : 0;
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, e);
      checkOutput($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 24; i++) begin
      logic [2:0]   rOp;
      logic [W-1:0] rA, rB;
      rOp = 3'($urandom_range(0, 7));
      rA  = W'($urandom);
      rB  = W'($urandom);
      applyStimulus(rOp, rA, rB, refModel(rOp, rA, rB));
      checkOutput($sformatf("rand%0d", i));
    end

    // Consumer stalls for five cycles while the source tries to issue another op.
    out_ready = 1'b0;
    applyStimulus(OP_ADD, 8'h03, 8'h04, refModel(OP_ADD, 8'h03, 8'h04));
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        in_valid = 1'b1;
        op = OP_SUB;
        a  = 8'h55;
        b  = 8'h11;
      end
      check($sformatf("stall%0d", k), 64'({out_valid, in_ready, result, carry, zero, overflow}),
            64'({1'b1, 1'b0, 8'h07, 3'b000}));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("stall_release");
    stray = 0;
    repeat (4) begin
      if (out_valid || !in_ready) stray++;
      @(posedge clk);
      #1;
    end
    check("stall_no_extra", 64'(stray), 64'(0));

    // Reset lands in the third cycle of a multiply; nothing may come out afterwards.
    applyStimulus(OP_MUL, 8'h10, 8'h20, refModel(OP_MUL, 8'h10, 8'h20));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sbQ.pop_back());
    check("mulrst_in_ready", 64'(in_ready), 64'(1));
    check("mulrst_outputs", 64'({out_valid, result, carry, zero, overflow}), 64'(0));
    stray = 0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (out_valid) stray++;
    end
    check("mulrst_no_stale", 64'(stray), 64'(0));

    applyStimulus(OP_MUL, 8'h07, 8'h06, refModel(OP_MUL, 8'h07, 8'h06));
    checkOutput("post_reset_mul");
    check("scoreboard_empty", 64'(sbQ.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, required finish before 500000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
